hazard_ctrl: RTL and testbench

- Pipeline controller for the 5-stage single-issue MIPS datapath: IF/ID, ID/EX, EX/MEM and MEM/WB buffers, with branches resolved in MEM.
- Sequences the pipeline by:
  - stalling on load-use hazards;
  - flushing on taken branches;
  - producing ALU operand forwarding selects;
  - running a debug halt handshake that drains the pipeline before acknowledging.
- Drives the PC write enable, IF/ID write/flush, ID/EX bubble and EX/MEM flush; also keeps stall and flush event counters.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/fwd_unit.sv | 30 +++
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states,
// ALU operand forwarding selects and the hard-wired zero register.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RD    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_unit.sv
// Operand forwarding select for one ALU source. The EX/MEM result is younger
// than the MEM/WB result, so it wins when both target the same register.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic       exmem_regwrite,
    input  logic [4:0] exmem_rd,
    input  logic       memwb_regwrite,
    input  logic [4:0] memwb_rd,
    input  logic [4:0] src_reg,
    output logic [1:0] sel
);

    logic hit_exmem;
    logic hit_memwb;

    // $zero never carries a forwardable value even if a write targets it.
    assign hit_exmem = exmem_regwrite && (exmem_rd != REG_ZERO) && (exmem_rd == src_reg);
    assign hit_memwb = memwb_regwrite && (memwb_rd != REG_ZERO) && (memwb_rd == src_reg);

    always_comb begin
        sel = FWD_RD;
        if (hit_exmem) begin
            sel = FWD_EXMEM;
        end else if (hit_memwb) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller for the 5-stage MIPS datapath: load-use stalls, branch
// flushes, operand forwarding and a draining debug-halt handshake.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rs,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_regwrite,
    input  logic [4:0]       exmem_rd,
    input  logic             memwb_regwrite,
    input  logic [4:0]       memwb_rd,
    input  logic             pcsrc,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halt_ack,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_e           state_q,     state_d;
    logic [DW-1:0]    drain_q,     drain_d;
    logic             halt_ack_q,  halt_ack_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       lu;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    fwd_unit u_fwd_a (
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .src_reg        (idex_rs),
        .sel            (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .src_reg        (idex_rt),
        .sel            (fwd_b_raw)
    );

    assign lu = idex_memread && (idex_rt != REG_ZERO) &&
                ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));

    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        halt_ack_d  = halt_ack_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
        exmem_flush = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (pcsrc) begin
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_ONE;
                end else if (halt_req) begin
                    // IF/ID is held rather than flushed so it resumes after the halt.
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else if (lu) begin
                    stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q : stall_cnt_q + CNT_ONE;
                end else begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    idex_bubble = 1'b0;
                end
            end
            ST_DRAIN: begin
                // An older branch can still resolve in MEM while draining.
                if (pcsrc) begin
                    pc_write    = 1'b1;
                    ifid_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    flush_cnt_d = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_ONE;
                end
                if (drain_q == '0) begin
                    state_d    = ST_HALTED;
                    halt_ack_d = 1'b1;
                end else begin
                    drain_d = drain_q - DRAIN_ONE;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d    = ST_RUN;
                    halt_ack_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_RUN;
                halt_ack_d = 1'b0;
            end
        endcase

        if (rst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_q     <= '0;
            halt_ack_q  <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            halt_ack_q  <= halt_ack_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fwd_a     = rst ? FWD_RD : fwd_a_raw;
    assign fwd_b     = rst ? FWD_RD : fwd_b_raw;
    assign halt_ack  = halt_ack_q && !rst;
    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, forwarding, load-use, branch flush,
// halt handshake, reset during drain and counter saturation (CNT_W=2 copy).
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
    logic       idex_memread, exmem_regwrite, memwb_regwrite, pcsrc, halt_req;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, halt_ack;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble, s_exmem_flush, s_halt_ack;
    logic [1:0]  s_fwd_a, s_fwd_b, s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int checks;
    int failures;

    hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .pcsrc(pcsrc), .halt_req(halt_req),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halt_ack(halt_ack), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
        .idex_memread(idex_memread), .idex_rs(idex_rs), .idex_rt(idex_rt),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
        .pcsrc(pcsrc), .halt_req(halt_req),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_bubble(s_idex_bubble), .exmem_flush(s_exmem_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halt_ack(s_halt_ack), .state(s_state),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_idle();
        ifid_rs = 5'd0; ifid_rt = 5'd0;
        idex_memread = 1'b0; idex_rs = 5'd0; idex_rt = 5'd0;
        exmem_regwrite = 1'b0; exmem_rd = 5'd0;
        memwb_regwrite = 1'b0; memwb_rd = 5'd0;
        pcsrc = 1'b0; halt_req = 1'b0;
    endtask

    task automatic drive_lu(input logic [4:0] rt);
        idex_memread = 1'b1;
        idex_rt      = rt;
        ifid_rt      = rt;
    endtask

    // Checker
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, need %0h", tag, got, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive_idle();
        rst = 1'b1;

        // Reset then idle
        tick();
        tick();
        check("rst_pc_write",    32'(pc_write),    32'd0);
        check("rst_ifid_write",  32'(ifid_write),  32'd0);
        check("rst_ifid_flush",  32'(ifid_flush),  32'd1);
        check("rst_idex_bubble", 32'(idex_bubble), 32'd1);
        check("rst_exmem_flush", 32'(exmem_flush), 32'd1);
        check("rst_halt_ack",    32'(halt_ack),    32'd0);
        check("rst_fwd_a",       32'(fwd_a),       32'd0);
        rst = 1'b0;
        settle();
        check("idle_state",      32'(state),       32'd0);
        check("idle_stall_cnt",  32'(stall_cnt),   32'd0);
        check("idle_flush_cnt",  32'(flush_cnt),   32'd0);
        check("idle_pc_write",   32'(pc_write),    32'd1);
        check("idle_ifid_write", 32'(ifid_write),  32'd1);
        check("idle_bubble",     32'(idex_bubble), 32'd0);

        // Forwarding
        exmem_regwrite = 1'b1; exmem_rd = 5'd5;
        memwb_regwrite = 1'b1; memwb_rd = 5'd5;
        idex_rs = 5'd5; idex_rt = 5'd5;
        settle();
        check("fwd_a_exmem_prio", 32'(fwd_a), 32'd2);
        check("fwd_b_exmem_prio", 32'(fwd_b), 32'd2);
        exmem_rd = 5'd0;
        settle();
        check("fwd_a_memwb", 32'(fwd_a), 32'd1);
        idex_rt = 5'd0; memwb_rd = 5'd0;
        settle();
        check("fwd_b_zero", 32'(fwd_b), 32'd0);
        check("fwd_a_zero", 32'(fwd_a), 32'd0);
        exmem_regwrite = 1'b0; exmem_rd = 5'd7; memwb_rd = 5'd7; idex_rt = 5'd7;
        settle();
        check("fwd_b_memwb_only", 32'(fwd_b), 32'd1);
        memwb_regwrite = 1'b0;
        settle();
        check("fwd_b_no_write", 32'(fwd_b), 32'd0);
        drive_idle();

        // Load-use on rt match: exactly one stall cycle
        drive_lu(5'd8);
        settle();
        check("lu_pc_write",   32'(pc_write),    32'd0);
        check("lu_ifid_write", 32'(ifid_write),  32'd0);
        check("lu_bubble",     32'(idex_bubble), 32'd1);
        check("lu_ifid_flush", 32'(ifid_flush),  32'd0);
        tick();
        drive_idle();
        settle();
        check("lu_stall_cnt",  32'(stall_cnt),   32'd1);
        check("lu_resume_pc",  32'(pc_write),    32'd1);
        idex_memread = 1'b1;
        settle();
        check("lu_rt0_pc_write", 32'(pc_write), 32'd1);
        tick();
        check("lu_rt0_stall_cnt", 32'(stall_cnt), 32'd1);
        idex_rt = 5'd9; ifid_rs = 5'd9;
        settle();
        check("lu_rs_bubble", 32'(idex_bubble), 32'd1);
        tick();
        drive_idle();
        check("lu_rs_stall_cnt", 32'(stall_cnt), 32'd2);

        // Branch beats halt and load-use in the same cycle
        pcsrc = 1'b1; halt_req = 1'b1; drive_lu(5'd8);
        settle();
        check("br_pc_write",    32'(pc_write),    32'd1);
        check("br_ifid_flush",  32'(ifid_flush),  32'd1);
        check("br_bubble",      32'(idex_bubble), 32'd1);
        check("br_exmem_flush", 32'(exmem_flush), 32'd1);
        tick();
        drive_idle();
        settle();
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd2);
        check("br_state",     32'(state),     32'd0);

        // Halt handshake with a branch resolving mid-drain
        halt_req = 1'b1;
        settle();
        check("hreq_pc_write",   32'(pc_write),   32'd0);
        check("hreq_ifid_write", 32'(ifid_write), 32'd0);
        check("hreq_ifid_flush", 32'(ifid_flush), 32'd0);
        tick();
        check("drain1_state",    32'(state),    32'd1);
        check("drain1_halt_ack", 32'(halt_ack), 32'd0);
        halt_req = 1'b0;
        settle();
        check("drain1_pc_write", 32'(pc_write), 32'd0);
        tick();
        check("drain2_state", 32'(state), 32'd1);
        pcsrc = 1'b1;
        settle();
        check("drain_br_pc_write",    32'(pc_write),    32'd1);
        check("drain_br_ifid_flush",  32'(ifid_flush),  32'd1);
        check("drain_br_exmem_flush", 32'(exmem_flush), 32'd1);
        check("drain_br_bubble",      32'(idex_bubble), 32'd1);
        tick();
        pcsrc = 1'b0; halt_req = 1'b1;
        settle();
        check("drain3_state",     32'(state),     32'd1);
        check("drain3_flush_cnt", 32'(flush_cnt), 32'd2);
        check("drain3_halt_ack",  32'(halt_ack),  32'd0);
        tick();
        check("halted_state",    32'(state),    32'd2);
        check("halted_halt_ack", 32'(halt_ack), 32'd1);
        check("halted_pc_write", 32'(pc_write), 32'd0);
        tick();
        check("halted_hold", 32'(state), 32'd2);
        halt_req = 1'b0;
        tick();
        check("resume_state",    32'(state),    32'd0);
        check("resume_halt_ack", 32'(halt_ack), 32'd0);
        check("resume_pc_write", 32'(pc_write), 32'd1);

        // Reset during drain
        halt_req = 1'b1;
        tick();
        tick();
        check("pre_rst_state", 32'(state), 32'd1);
        rst = 1'b1;
        settle();
        check("rst_drain_pc_write", 32'(pc_write), 32'd0);
        tick();
        rst = 1'b0;
        halt_req = 1'b0;
        settle();
        check("rst_drain_state",     32'(state),     32'd0);
        check("rst_drain_halt_ack",  32'(halt_ack),  32'd0);
        check("rst_drain_stall_cnt", 32'(stall_cnt), 32'd0);
        check("sat_flush_cnt_rst",   32'(s_flush_cnt), 32'd0);

        // Saturation: five consecutive load-use stalls
        drive_lu(5'd3);
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 3) check("sat_stall_at3", 32'(s_stall_cnt), 32'd3);
            if (i == 4) check("sat_stall_at4", 32'(s_stall_cnt), 32'd3);
        end
        drive_idle();
        settle();
        check("sat_stall_cnt",  32'(s_stall_cnt), 32'd3);
        check("wide_stall_cnt", 32'(stall_cnt),   32'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
